// File: rtl/fpmul_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fpmul_pkg
//  Description : Shared state encoding and IEEE-754 constants for the
//                sequential single-precision multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
package fpmul_pkg;

    // Controller states; encodings 3'b100..3'b111 are illegal
    typedef enum logic [2:0] {
        ST_IDLE = 3'b000,
        ST_LOAD = 3'b001,
        ST_ITER = 3'b010,
        ST_DONE = 3'b011
    } state_t;

    localparam int          BIAS    = 127;
    localparam int          EXP_MAX = 255;
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam int          MANT_W  = 24;

endpackage
`default_nettype wire

// File: rtl/fp32_seq_mul_if.sv
`default_nettype none
// ============================================================================
//  Module      : fp32_seq_mul_if
//  Description : Operand request / result bundle of the sequential FP32
//                multiplier. The master issues operands, the slave multiplies.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fp32_seq_mul_if;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        valid;
    logic [31:0] p;
    logic [2:0]  state;

    modport master (output start, a, b, input busy, valid, p, state);
    modport slave  (input start, a, b, output busy, valid, p, state);
endinterface
`default_nettype wire

// File: rtl/fpmul_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : fpmul_ctrl_fsm
//  Description : Control state machine of the sequential FP32 multiplier.
//                DONE is held for two cycles: the first carries the pack
//                strobe, the second lets the result settle before IDLE.
//  Revision    : 1.0 - initial release
// ============================================================================
module fpmul_ctrl_fsm
    import fpmul_pkg::*;
(
    input  wire logic   clk,
    input  wire logic   rst_n,
    input  wire logic   start,
    input  wire logic   more,
    output state_t      o_state,
    output logic        o_busy,
    output logic        o_pack
);

    state_t r_state;
    logic   r_busy;
    logic   r_pack;

    // State register, next-state decision and registered control outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_pack  <= 1'b0;
        end else begin
            r_pack <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_LOAD;
                        r_busy  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    r_state <= ST_ITER;
                end
                ST_ITER: begin
                    if (!more) begin
                        r_state <= ST_DONE;
                        r_pack  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    // First DONE cycle still has the strobe up; leave on the second
                    if (!r_pack) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_state = r_state;
    assign o_busy  = r_busy;
    assign o_pack  = r_pack;

endmodule
`default_nettype wire

// File: rtl/fp32_seq_mul.sv
`default_nettype none
// ============================================================================
//  Module      : fp32_seq_mul
//  Description : Sequential IEEE-754 single-precision multiplier. Mantissas
//                are multiplied by shift-add, one bit per clock; special
//                operands still take the full, data-independent latency.
//                Optional macro FPMUL_RNE_EN selects round-to-nearest-even;
//                without it the product is truncated toward zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp32_seq_mul
    import fpmul_pkg::*;
#(
    parameter int MANT_W = fpmul_pkg::MANT_W
)(
    input  wire logic       clk,
    input  wire logic       rst_n,
    fp32_seq_mul_if.slave   bus
);

    localparam int PW     = 2 * MANT_W;
    localparam int FRAC_W = MANT_W - 1;
    localparam int CNT_W  = $clog2(MANT_W);

    // Controller interface
    state_t w_state;
    logic   w_busy;
    logic   w_pack;
    logic   w_more;

    // Latched operands and unpacked fields
    logic [31:0]        r_a;
    logic [31:0]        r_b;
    logic               r_sign;
    logic [7:0]         r_ea;
    logic [7:0]         r_eb;
    logic [MANT_W-1:0]  r_mcand;
    logic [MANT_W-1:0]  r_mplier;
    logic [PW-1:0]      r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_nan;
    logic               r_inf;
    logic               r_zero;
    logic [31:0]        r_p;
    logic               r_valid;

    fpmul_ctrl_fsm u_ctrl (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (bus.start),
        .more    (w_more),
        .o_state (w_state),
        .o_busy  (w_busy),
        .o_pack  (w_pack)
    );

    // ------------------------------------------------------------------
    // Unpack: denormal inputs (exp = 0) are flushed to zero
    // ------------------------------------------------------------------
    logic              w_zero_a, w_zero_b, w_inf_a, w_inf_b, w_nan_a, w_nan_b;
    logic [MANT_W-1:0] w_ma, w_mb;

    assign w_zero_a = (r_a[30:23] == 8'd0);
    assign w_zero_b = (r_b[30:23] == 8'd0);
    assign w_inf_a  = (r_a[30:23] == 8'hFF) && (r_a[22:0] == 23'd0);
    assign w_inf_b  = (r_b[30:23] == 8'hFF) && (r_b[22:0] == 23'd0);
    assign w_nan_a  = (r_a[30:23] == 8'hFF) && (r_a[22:0] != 23'd0);
    assign w_nan_b  = (r_b[30:23] == 8'hFF) && (r_b[22:0] != 23'd0);
    assign w_ma     = w_zero_a ? '0 : {1'b1, r_a[22:0]};
    assign w_mb     = w_zero_b ? '0 : {1'b1, r_b[22:0]};

    // ------------------------------------------------------------------
    // Shift-add step: add multiplicand into the upper half, shift right
    // ------------------------------------------------------------------
    logic [MANT_W-1:0] w_addend;
    logic [MANT_W:0]   w_sum;
    logic [PW-1:0]     w_acc_next;

    assign w_addend   = r_mplier[0] ? r_mcand : '0;
    assign w_sum      = {1'b0, r_acc[PW-1:MANT_W]} + {1'b0, w_addend};
    assign w_acc_next = {w_sum, r_acc[MANT_W-1:1]};
    assign w_more     = (r_cnt != '0);

    // ------------------------------------------------------------------
    // Normalize: bring the leading one to the top bit of the product
    // ------------------------------------------------------------------
    logic              w_top;
    logic [PW-1:0]     w_norm;
    logic [FRAC_W-1:0] w_frac_t;
    logic [9:0]        w_exp_base;
    logic [FRAC_W-1:0] w_frac;
    logic [9:0]        w_exp;
    logic              w_unused_norm;

    assign w_top      = r_acc[PW-1];
    assign w_norm     = w_top ? r_acc : {r_acc[PW-2:0], 1'b0};
    assign w_frac_t   = w_norm[PW-2:MANT_W];
    assign w_exp_base = {2'b00, r_ea} + {2'b00, r_eb} - 10'(BIAS) + {9'd0, w_top};

`ifdef FPMUL_RNE_EN
    logic              w_guard, w_round, w_sticky, w_rnd_up;
    logic [FRAC_W:0]   w_frac_inc;

    assign w_guard       = w_norm[MANT_W-1];
    assign w_round       = w_norm[MANT_W-2];
    assign w_sticky      = |w_norm[MANT_W-3:0];
    assign w_rnd_up      = w_guard & (w_round | w_sticky | w_frac_t[0]);
    assign w_frac_inc    = {1'b0, w_frac_t} + {{FRAC_W{1'b0}}, w_rnd_up};
    // A carry out of the fraction leaves it all-zero and bumps the exponent
    assign w_frac        = w_frac_inc[FRAC_W-1:0];
    assign w_exp         = w_exp_base + {9'd0, w_frac_inc[FRAC_W]};
    assign w_unused_norm = w_norm[PW-1];
`else
    assign w_frac        = w_frac_t;
    assign w_exp         = w_exp_base;
    assign w_unused_norm = ^{w_norm[PW-1], w_norm[MANT_W-1:0]};
`endif

    // ------------------------------------------------------------------
    // Pack with special-case priority: NaN, inf, zero, overflow, underflow
    // ------------------------------------------------------------------
    logic [31:0] w_result;

    // Final result selection
    always_comb begin
        w_result = {r_sign, w_exp[7:0], w_frac};
        if (r_nan) begin
            w_result = QNAN;
        end else if (r_inf) begin
            w_result = {r_sign, 8'hFF, 23'd0};
        end else if (r_zero) begin
            w_result = {r_sign, 31'd0};
        end else if ($signed(w_exp) >= $signed(10'(EXP_MAX))) begin
            w_result = {r_sign, 8'hFF, 23'd0};
        end else if ($signed(w_exp) <= $signed(10'd0)) begin
            w_result = {r_sign, 31'd0};
        end
    end

    // Datapath registers sequenced by the controller state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_sign   <= 1'b0;
            r_ea     <= '0;
            r_eb     <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_nan    <= 1'b0;
            r_inf    <= 1'b0;
            r_zero   <= 1'b0;
            r_p      <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= w_pack;
            if (w_pack) begin
                r_p <= w_result;
            end
            case (w_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_a <= bus.a;
                        r_b <= bus.b;
                    end
                end
                ST_LOAD: begin
                    r_sign   <= r_a[31] ^ r_b[31];
                    r_ea     <= r_a[30:23];
                    r_eb     <= r_b[30:23];
                    r_mcand  <= w_ma;
                    r_mplier <= w_mb;
                    r_acc    <= '0;
                    r_cnt    <= CNT_W'(MANT_W - 1);
                    r_nan    <= w_nan_a | w_nan_b | (w_zero_a & w_inf_b) | (w_inf_a & w_zero_b);
                    r_inf    <= w_inf_a | w_inf_b;
                    r_zero   <= w_zero_a | w_zero_b;
                end
                ST_ITER: begin
                    r_acc    <= w_acc_next;
                    r_mplier <= r_mplier >> 1;
                    if (w_more) begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy  = w_busy;
    assign bus.valid = r_valid;
    assign bus.p     = r_p;
    assign bus.state = w_state;

endmodule
`default_nettype wire

// File: doc/fp32_seq_mul.md
# fp32_seq_mul

Sequential IEEE-754 single-precision multiplier: the datapath and iteration counter driven by the multiplier control state machine. It accepts two operands on a start/busy handshake and produces the 24×24 mantissa product by shift-add, one bit per cycle. It reports loop completion back to the controller and returns a packed 32-bit result with a one-cycle valid pulse. It sits between the operand-issue logic and the result consumer in the FP multiplier top level.

## Interface
- `MANT_W`, default 24: mantissa width including the hidden bit; fixes the iteration count.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: operand request, sampled only in IDLE.
- `a` in 32: operand A, IEEE-754 single.
- `b` in 32: operand B, IEEE-754 single.
- `busy` out 1: high in every state except IDLE.
- `valid` out 1: one-cycle pulse; `p` is meaningful while it is high.
- `p` out 32: product, held until the next `valid`.
- `state` out 3: current state, for debug and trace.

## Operation
- States: IDLE=3'b000, LOAD=3'b001, ITER=3'b010, DONE=3'b011. Encodings 3'b100–3'b111 are illegal and return to IDLE.
- IDLE: `start`=1 latches `a`, `b` and moves to LOAD.
- LOAD:
  - Unpack sign, exponent and mantissa; prepend the hidden bit.
  - Clear the 48-bit accumulator; set the counter to MANT_W-1.
  - Compute the flags: zero, inf, NaN. A denormal input (exp=0) is flushed to zero.
  - Move to ITER.
- ITER:
  - Each cycle: if multiplier LSB is 1, add the multiplicand to the upper accumulator half; shift right one bit.
  - `more` = (counter != 0). While `more`=1, decrement the counter and stay in ITER.
  - When `more`=0, move to DONE.
- DONE: normalize, round, pack, register `p`, assert `valid`, return to IDLE.
- Arithmetic:
  - Sign = sa ^ sb.
  - Exponent is computed in 10-bit signed: ea + eb − 127, plus 1 if product bit 47 is set.
  - The mantissa is taken from bits 46:24 or 45:23 accordingly.
- Special-case priority:
  - NaN on either input, or 0×inf: 32'h7FC00000.
  - Inf on either input: signed inf.
  - Zero on either input: signed zero.
  - Exponent ≥ 255 after rounding: signed inf.
  - Exponent ≤ 0: signed zero. Denormal outputs are never produced.
- Special cases take the full latency; latency is data-independent.

## Timing
- Reset values: state=IDLE, `busy`=0, `valid`=0, `p`=32'h0, accumulator and counter cleared.
- `start` sampled at edge E0 → LOAD after E0 → ITER after E1 → 24 ITER cycles (E2..E25) → DONE after E25.
- `valid`=1 and the new `p` are visible after E26 (latency 26 clocks); IDLE after E27.
- `busy` rises after E0 and falls after E27. The next `start` can be accepted at E28.
- `start` while `busy`=1 is ignored, not queued. `a` and `b` may change freely after E0.
- `start` held high continuously restarts at each IDLE visit. Back-to-back throughput: one result per 28 clocks.
- `rst_n` low mid-operation: immediate return to IDLE; `valid` and `p` cleared; no partial result emitted.
- `p` is not updated outside DONE.

## Configuration
- `FPMUL_RNE_EN` defined: round-to-nearest-even using guard, round and sticky bits. A mantissa carry-out increments the exponent and may overflow to inf.
- Undefined: truncation toward zero; guard and sticky logic are not compiled.

## Structure
- Package `fpmul_pkg` holds:
  - the state typedef and encodings;
  - BIAS=127, EXP_MAX=255, QNAN=32'h7FC00000, MANT_W=24.
- Sub-module `fpmul_ctrl_fsm`: state register plus next-state logic, with inputs `start` and `more`.
- The datapath (unpack, shift-add, normalize, round, pack) stays in `fp32_seq_mul`.

## Test plan
- a=32'h3FC00000, b=32'h40000000 → `p`=32'h40400000, `valid` pulse exactly 26 clocks after `start`.
- a=32'h00000000, b=32'h7F800000 → 32'h7FC00000. a=32'hFF800000, b=32'h40000000 → 32'hFF800000.
- a=b=32'h7F000000 → 32'h7F800000 (overflow). a=b=32'h00800000 → 32'h00000000 (underflow).
- a=b=32'h3FC00001 → 32'h40100002 with FPMUL_RNE_EN, 32'h40100001 without it.
- `start` pulsed at E5 during a busy operation → ignored; exactly one `valid`, with the first result.
- `rst_n` low during ITER → `busy`=0, `valid`=0, `p`=0 immediately. A following `start` completes normally in 26 clocks.
